pad_mux_ctrl: RTL and testbench
===============================

// Module: pad_mux_ctrl
// PURPOSE
//  Runtime-configurable bidir pad multiplexer, successor to the fixed per-pad tie-offs in the chip core.
//  Routes one of NUM_FUNC peripheral functions to each of NUM_PADS bidir pads.
//  Holds per-pad electrical config (pu/pd/sl/cs/mode) in Wishbone-writable registers.
//  Synchronises pad inputs before they reach the SoC. Sits between the SoC peripherals and the pad ring.
// PARAMETERS
//  NUM_PADS     16  number of bidir pads handled (1..32)
//  NUM_FUNC     4   functions selectable per pad (1..16)
//  SYNC_STAGES  2   input synchroniser depth (>=2)
//  ADR_W        6   Wishbone word-address width (2^ADR_W >= NUM_PADS+2)
// PORTS
//  clk_i       in   1                  clock
//  rst_i       in   1                  reset, asynchronous, active-high
//  wb_cyc_i    in   1                  Wishbone cycle
//  wb_stb_i    in   1                  Wishbone strobe
//  wb_we_i     in   1                  Wishbone write enable
//  wb_adr_i    in   ADR_W              word address
//  wb_dat_i    in   32                 write data
//  wb_dat_o    out  32                 read data
//  wb_ack_o    out  1                  acknowledge
//  func_out_i  in   NUM_PADS*NUM_FUNC  function output value, index p*NUM_FUNC+f
//  func_oe_i   in   NUM_PADS*NUM_FUNC  function output enable, same indexing
//  func_in_o   out  NUM_PADS*NUM_FUNC  synchronised input to function, same indexing
//  pad_in_i    in   NUM_PADS           raw pad input value
//  pad_out_o   out  NUM_PADS           pad output value
//  pad_oe_o    out  NUM_PADS           pad output enable
//  pad_ie_o    out  NUM_PADS           pad input enable
//  pad_cs_o    out  NUM_PADS           0 = CMOS input buffer, 1 = Schmitt trigger
//  pad_sl_o    out  NUM_PADS           slew control bit to the pad
//  pad_pu_o    out  NUM_PADS           pull-up
//  pad_pd_o    out  NUM_PADS           pull-down
// BEHAVIOUR
//  Register map (word address)
//  - addr p < NUM_PADS: PADCFG[p]
//    - [3:0] fsel, [4] pu, [5] pd, [6] sl, [7] cs, [9:8] mode, [10] drv; other bits read 0.
//  - addr NUM_PADS: LOCK, bit0.
//  - addr NUM_PADS+1: PADIN, synchronised pad inputs, read-only.
//  - Any other address reads 0; writes to it are ignored.
//  Reset values
//  - PADCFG = fsel 0, mode 01, pd 1, all other bits 0. LOCK = 0.
//  - All synchroniser flops = 0.
//  - wb_ack_o = 0, wb_dat_o = 0.
//  Wishbone handshake
//  - A request is cyc&stb with ack low. ack rises at the next edge for exactly one cycle, then returns to 0.
//  - wb_dat_o is valid while ack=1 and is 0 otherwise.
//  - Every address is acked, including unmapped and locked ones.
//  - A write updates the register at the same edge that raises ack.
//  - A write of pu=1,pd=1 stores pu=1, pd=0: pull-up has priority.
//  - Writing LOCK bit0=1 sets LOCK. LOCK is sticky and cleared only by rst_i.
//  - While LOCK=1, PADCFG writes are acked and discarded.
//  Mode, decoded combinationally from the registers
//  - 00 function: out=func_out[p,fsel], oe=func_oe[p,fsel], ie=~oe.
//  - 01 input: oe=0, ie=1, out=0.
//  - 10 force: oe=1, ie=0, out=drv.
//  - 11 off: oe=0, ie=0, out=0.
//  - In mode 00, fsel >= NUM_FUNC behaves as mode 11.
//  - pad_cs_o, pad_sl_o, pad_pu_o and pad_pd_o follow PADCFG directly in every mode.
//  Input path
//  - pad_in_i[p] passes through SYNC_STAGES flops to give sync[p]. Latency is SYNC_STAGES edges.
//  - func_in_o[p,f] = sync[p] when f==fsel and mode is 00 or 01.
//  - Otherwise func_in_o[p,f] = pu[p], the idle level, e.g. UART rx idle high.
//  - PADIN bit p = sync[p]; bits >= NUM_PADS read 0.
//  Reset mid-transaction
//  - Asserting rst_i drops ack immediately. No partial register write occurs.
//  - The requester retries after reset.
// TESTING
//  - Reset: check pad_oe=0, ie=1, pd=1, pu=0 on all pads; ack=0; LOCK read = 0.
//  - Write PADCFG[3]=0x001 (fsel1, mode00); drive func_oe[3,1]=1, func_out[3,1]=1 -> pad_oe[3]=1, pad_out[3]=1, pad_ie[3]=0; ack high exactly 1 cycle.
//  - Pad 7 configured fsel2, mode00, pu=1; toggle pad_in_i[7] 0->1 -> func_in_o[7,2] rises after 2 edges; func_in_o[7,0]=1 constant.
//  - Write pu=pd=1 to PADCFG[0] -> readback 0x010. Write fsel=9 with NUM_FUNC=4 -> pad 0 oe=0, ie=0.
//  - Write LOCK=1, then PADCFG[2]=0x600 -> acked; readback unchanged 0x120; pad 2 outputs unchanged; pulse rst_i -> LOCK=0.
//  - Read addr NUM_PADS+5 -> 0 with ack. Assert rst_i while ack is pending -> ack=0 and the register is not written.

Source files
------------

// File: rtl/pad_mux_ctrl.sv
// rtl/pad_mux_ctrl.sv - runtime-configurable bidir pad multiplexer with Wishbone config registers
`timescale 1ns/1ps
module pad_mux_ctrl #(
    parameter int NUM_PADS    = 16,
    parameter int NUM_FUNC    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ADR_W       = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic [ADR_W-1:0]             wb_adr_i,
    input  logic [31:0]                  wb_dat_i,
    output logic [31:0]                  wb_dat_o,
    output logic                         wb_ack_o,
    input  logic [NUM_PADS*NUM_FUNC-1:0] func_out_i,
    input  logic [NUM_PADS*NUM_FUNC-1:0] func_oe_i,
    output logic [NUM_PADS*NUM_FUNC-1:0] func_in_o,
    input  logic [NUM_PADS-1:0]          pad_in_i,
    output logic [NUM_PADS-1:0]          pad_out_o,
    output logic [NUM_PADS-1:0]          pad_oe_o,
    output logic [NUM_PADS-1:0]          pad_ie_o,
    output logic [NUM_PADS-1:0]          pad_cs_o,
    output logic [NUM_PADS-1:0]          pad_sl_o,
    output logic [NUM_PADS-1:0]          pad_pu_o,
    output logic [NUM_PADS-1:0]          pad_pd_o
);

    // PADCFG layout: [3:0] fsel, [4] pu, [5] pd, [6] sl, [7] cs, [9:8] mode, [10] drv
    localparam logic [10:0]      CFG_RST   = 11'h120;
    localparam logic [ADR_W-1:0] LOCK_ADR  = ADR_W'(NUM_PADS);
    localparam logic [ADR_W-1:0] PADIN_ADR = ADR_W'(NUM_PADS + 1);

    logic [10:0]         cfg [NUM_PADS];
    logic                lock;
    logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PADS-1:0] sync;
    logic [31:0]         rd_data;
    logic                req;
    logic                unused_dat;

    // Only the low 11 data bits are ever stored
    assign unused_dat = ^wb_dat_i[31:11];

    // A new request is only taken while ack is low, so each access acks for one cycle
    assign req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign sync = sync_q[SYNC_STAGES-1];

    // Register read mux; unmapped addresses and unused bits read as zero
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (wb_adr_i == ADR_W'(p)) begin
                rd_data[10:0] = cfg[p];
            end
        end
        if (wb_adr_i == LOCK_ADR) begin
            rd_data[0] = lock;
        end
        if (wb_adr_i == PADIN_ADR) begin
            rd_data[NUM_PADS-1:0] = sync;
        end
    end

    // Wishbone slave: ack/data registering, PADCFG writes (pull-up wins) and sticky LOCK
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            lock     <= 1'b0;
            for (int p = 0; p < NUM_PADS; p++) begin
                cfg[p] <= CFG_RST;
            end
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= req ? rd_data : '0;
            if (req && wb_we_i) begin
                for (int p = 0; p < NUM_PADS; p++) begin
                    if (!lock && wb_adr_i == ADR_W'(p)) begin
                        cfg[p] <= {wb_dat_i[10:6], wb_dat_i[5] & ~wb_dat_i[4], wb_dat_i[4:0]};
                    end
                end
                if (wb_adr_i == LOCK_ADR && wb_dat_i[0]) begin
                    lock <= 1'b1;
                end
            end
        end
    end

    // Input synchroniser chain, SYNC_STAGES flops deep
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pad_in_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [3:0] fsel;
        logic [1:0] mode;
        logic       sel_out;
        logic       sel_oe;
        logic       fsel_ok;
        logic       out_d;
        logic       oe_d;
        logic       ie_d;

        assign fsel = cfg[p][3:0];
        assign mode = cfg[p][9:8];

        // Pick the selected function's out/oe; an fsel beyond NUM_FUNC matches nothing
        always_comb begin
            sel_out = 1'b0;
            sel_oe  = 1'b0;
            fsel_ok = 1'b0;
            for (int f = 0; f < NUM_FUNC; f++) begin
                if (fsel == 4'(f)) begin
                    sel_out = func_out_i[p*NUM_FUNC+f];
                    sel_oe  = func_oe_i[p*NUM_FUNC+f];
                    fsel_ok = 1'b1;
                end
            end
        end

        // Mode decode: function, input, force-drive, off
        always_comb begin
            out_d = 1'b0;
            oe_d  = 1'b0;
            ie_d  = 1'b0;
            case (mode)
                2'b00: begin
                    if (fsel_ok) begin
                        out_d = sel_out;
                        oe_d  = sel_oe;
                        ie_d  = ~sel_oe;
                    end
                end
                2'b01: ie_d = 1'b1;
                2'b10: begin
                    oe_d  = 1'b1;
                    out_d = cfg[p][10];
                end
                default: ;
            endcase
        end

        assign pad_out_o[p] = out_d;
        assign pad_oe_o[p]  = oe_d;
        assign pad_ie_o[p]  = ie_d;
        assign pad_pu_o[p]  = cfg[p][4];
        assign pad_pd_o[p]  = cfg[p][5];
        assign pad_sl_o[p]  = cfg[p][6];
        assign pad_cs_o[p]  = cfg[p][7];

        // Unselected functions see the pull-up level so idle-high peripherals stay quiet
        for (genvar f = 0; f < NUM_FUNC; f++) begin : g_fin
            assign func_in_o[p*NUM_FUNC+f] = (~mode[1] && fsel == 4'(f)) ? sync[p] : cfg[p][4];
        end
    end

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// tb/tb_pad_mux_ctrl.sv - self-checking bench for pad_mux_ctrl
`timescale 1ns/1ps
module tb_pad_mux_ctrl;

    localparam int NP = 16;
    localparam int NF = 4;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we  = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [31:0]   wdat = '0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic [NP*NF-1:0] func_out = '0;
    logic [NP*NF-1:0] func_oe  = '0;
    logic [NP*NF-1:0] func_in;
    logic [NP-1:0] pad_in = '0;
    logic [NP-1:0] pad_out, pad_oe, pad_ie, pad_cs, pad_sl, pad_pu, pad_pd;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    pad_mux_ctrl #(.NUM_PADS(NP), .NUM_FUNC(NF), .SYNC_STAGES(2), .ADR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_dat_i(wdat), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .func_out_i(func_out), .func_oe_i(func_oe), .func_in_o(func_in),
        .pad_in_i(pad_in), .pad_out_o(pad_out), .pad_oe_o(pad_oe), .pad_ie_o(pad_ie),
        .pad_cs_o(pad_cs), .pad_sl_o(pad_sl), .pad_pu_o(pad_pu), .pad_pd_o(pad_pd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One bus transaction; waits a bounded number of edges for ack
    task automatic wb_cycle(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                            output logic got_ack, output logic [31:0] rdat, output logic ack_after);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        got_ack = 1'b0;
        rdat = 'x;
        for (int i = 0; i < 4 && !got_ack; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin
                got_ack = 1'b1;
                rdat = wb_dat_o;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        ack_after = wb_ack_o;
    endtask

    task automatic test_reset();
        logic ga, aa;
        logic [31:0] rd, ex;
        do_reset();
        #1;
        n_checks++; if (pad_oe !== '0) begin n_fail++; $display("FAIL reset_oe got %h exp %h", pad_oe, 16'h0); end
        n_checks++; if (pad_ie !== '1) begin n_fail++; $display("FAIL reset_ie got %h exp %h", pad_ie, 16'hffff); end
        n_checks++; if (pad_pd !== '1) begin n_fail++; $display("FAIL reset_pd got %h exp %h", pad_pd, 16'hffff); end
        n_checks++; if (pad_pu !== '0) begin n_fail++; $display("FAIL reset_pu got %h exp %h", pad_pu, 16'h0); end
        n_checks++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", wb_ack_o); end
        n_checks++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat got %h exp 0", wb_dat_o); end
        n_checks++; if (func_in !== '0) begin n_fail++; $display("FAIL reset_func_in got %h exp 0", func_in); end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h120);
        wb_cycle(1'b0, AW'(NP), 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL reset_lock_read ack %b got %h exp %h", ga, rd, ex); end
        wb_cycle(1'b0, 6'd5, 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL reset_cfg_read ack %b got %h exp %h", ga, rd, ex); end
    endtask

    task automatic test_function_mode();
        logic ga, aa;
        logic [31:0] rd, ex;
        @(negedge clk);
        func_oe[3*NF+1]  = 1'b1;
        func_out[3*NF+1] = 1'b1;
        func_out[3*NF+0] = 1'b0;
        wb_cycle(1'b1, 6'd3, 32'h001, ga, rd, aa);
        n_checks++; if (ga !== 1'b1) begin n_fail++; $display("FAIL func_write_ack got %b exp 1", ga); end
        n_checks++; if (aa !== 1'b0) begin n_fail++; $display("FAIL func_ack_one_cycle got %b exp 0", aa); end
        n_checks++; if ({pad_oe[3], pad_out[3], pad_ie[3]} !== 3'b110) begin n_fail++;
            $display("FAIL func_pad3 oe/out/ie got %b exp 110", {pad_oe[3], pad_out[3], pad_ie[3]}); end
        @(negedge clk);
        func_oe[3*NF+1]  = 1'b0;
        func_out[3*NF+0] = 1'b1;
        func_oe[3*NF+0]  = 1'b1;
        #1;
        n_checks++; if ({pad_oe[3], pad_out[3], pad_ie[3]} !== 3'b011) begin n_fail++;
            $display("FAIL func_pad3_oe_off oe/out/ie got %b exp 011", {pad_oe[3], pad_out[3], pad_ie[3]}); end
        exp_q.push_back(32'h001);
        wb_cycle(1'b0, 6'd3, 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL func_readback ack %b got %h exp %h", ga, rd, ex); end
        func_oe = '0; func_out = '0;
    endtask

    task automatic test_input_sync();
        logic ga, aa;
        logic [31:0] rd, ex;
        wb_cycle(1'b1, 6'd7, 32'h012, ga, rd, aa);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (func_in[7*NF+3 -: 4] !== 4'b1011) begin n_fail++;
            $display("FAIL sync_idle pad7 func_in got %b exp 1011", func_in[7*NF+3 -: 4]); end
        @(negedge clk);
        pad_in[7] = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (func_in[7*NF+2] !== 1'b0) begin n_fail++; $display("FAIL sync_edge1 got %b exp 0", func_in[7*NF+2]); end
        @(posedge clk); #1;
        n_checks++; if (func_in[7*NF+2] !== 1'b1) begin n_fail++; $display("FAIL sync_edge2 got %b exp 1", func_in[7*NF+2]); end
        n_checks++; if (func_in[7*NF+0] !== 1'b1) begin n_fail++; $display("FAIL sync_func0_idle got %b exp 1", func_in[7*NF+0]); end
        exp_q.push_back(32'h0000_0080);
        wb_cycle(1'b0, AW'(NP+1), 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL padin_read ack %b got %h exp %h", ga, rd, ex); end
        pad_in = '0;
    endtask

    task automatic test_cfg_modes();
        logic ga, aa;
        logic [31:0] rd, ex;
        wb_cycle(1'b1, 6'd0, 32'h030, ga, rd, aa);
        exp_q.push_back(32'h010);
        wb_cycle(1'b0, 6'd0, 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL pu_priority_read ack %b got %h exp %h", ga, rd, ex); end
        n_checks++; if ({pad_pu[0], pad_pd[0]} !== 2'b10) begin n_fail++; $display("FAIL pu_priority_pins got %b exp 10", {pad_pu[0], pad_pd[0]}); end
        @(negedge clk);
        func_oe[3:0] = 4'hf; func_out[3:0] = 4'hf;
        wb_cycle(1'b1, 6'd0, 32'h009, ga, rd, aa);
        n_checks++; if ({pad_oe[0], pad_ie[0], pad_out[0]} !== 3'b000) begin n_fail++;
            $display("FAIL bad_fsel oe/ie/out got %b exp 000", {pad_oe[0], pad_ie[0], pad_out[0]}); end
        n_checks++; if (func_in[3:0] !== 4'b0000) begin n_fail++; $display("FAIL bad_fsel_func_in got %b exp 0000", func_in[3:0]); end
        func_oe = '0; func_out = '0;
        wb_cycle(1'b1, 6'd1, 32'h6c0, ga, rd, aa);
        n_checks++; if ({pad_oe[1], pad_ie[1], pad_out[1], pad_cs[1], pad_sl[1]} !== 5'b10111) begin n_fail++;
            $display("FAIL force_mode oe/ie/out/cs/sl got %b exp 10111", {pad_oe[1], pad_ie[1], pad_out[1], pad_cs[1], pad_sl[1]}); end
        wb_cycle(1'b1, 6'd1, 32'h300, ga, rd, aa);
        n_checks++; if ({pad_oe[1], pad_ie[1], pad_out[1]} !== 3'b000) begin n_fail++;
            $display("FAIL off_mode oe/ie/out got %b exp 000", {pad_oe[1], pad_ie[1], pad_out[1]}); end
    endtask

    task automatic test_unmapped();
        logic ga, aa;
        logic [31:0] rd, ex;
        wb_cycle(1'b1, AW'(NP+5), 32'hffff_ffff, ga, rd, aa);
        n_checks++; if (ga !== 1'b1) begin n_fail++; $display("FAIL unmapped_write_ack got %b exp 1", ga); end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        wb_cycle(1'b0, AW'(NP+5), 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL unmapped_read ack %b got %h exp %h", ga, rd, ex); end
        wb_cycle(1'b0, 6'd63, 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL unmapped_top_read ack %b got %h exp %h", ga, rd, ex); end
    endtask

    task automatic test_lock();
        logic ga, aa;
        logic [31:0] rd, ex;
        wb_cycle(1'b1, AW'(NP), 32'h1, ga, rd, aa);
        exp_q.push_back(32'h1);
        wb_cycle(1'b0, AW'(NP), 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL lock_set_read ack %b got %h exp %h", ga, rd, ex); end
        wb_cycle(1'b1, 6'd2, 32'h600, ga, rd, aa);
        n_checks++; if (ga !== 1'b1) begin n_fail++; $display("FAIL locked_write_ack got %b exp 1", ga); end
        exp_q.push_back(32'h120);
        wb_cycle(1'b0, 6'd2, 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL locked_readback ack %b got %h exp %h", ga, rd, ex); end
        n_checks++; if ({pad_oe[2], pad_ie[2], pad_pd[2]} !== 3'b011) begin n_fail++;
            $display("FAIL locked_pad2 oe/ie/pd got %b exp 011", {pad_oe[2], pad_ie[2], pad_pd[2]}); end
        wb_cycle(1'b1, AW'(NP), 32'h0, ga, rd, aa);
        exp_q.push_back(32'h1);
        wb_cycle(1'b0, AW'(NP), 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL lock_sticky ack %b got %h exp %h", ga, rd, ex); end
        do_reset();
        exp_q.push_back(32'h0);
        wb_cycle(1'b0, AW'(NP), 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL lock_cleared ack %b got %h exp %h", ga, rd, ex); end
    endtask

    task automatic test_reset_mid_txn();
        logic ga, aa;
        logic [31:0] rd, ex;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 6'd4; wdat = 32'h600;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_pending_ack got %b exp 0", wb_ack_o); end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        exp_q.push_back(32'h120);
        wb_cycle(1'b0, 6'd4, 32'h0, ga, rd, aa);
        ex = exp_q.pop_front();
        n_checks++; if (!ga || rd !== ex) begin n_fail++; $display("FAIL rst_no_write ack %b got %h exp %h", ga, rd, ex); end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'd4;
        @(posedge clk); #1;
        n_checks++; if (wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ack got %b exp 1", wb_ack_o); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({wb_ack_o, wb_dat_o} !== 33'h0) begin n_fail++;
            $display("FAIL rst_async_drop ack %b dat %h exp 0 0", wb_ack_o, wb_dat_o); end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_function_mode();
        test_input_sync();
        test_cfg_modes();
        test_unmapped();
        test_lock();
        test_reset_mid_txn();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
